// File: rtl/score_seg_display.sv
// score_seg_display: binary score to N-digit active-low seven-segment readout.
// A load captures `value`; a serial double-dabble engine builds BCD in a shadow
// register, then the DONE cycle commits it (or all 9s on overflow) to the
// display bank that feeds the segment decoders.
// Optional feature macro: SCORE_SEG_LZ_BLANK_EN (blank leading zero digits).
module score_seg_display #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned BIN_W  = 20
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [BIN_W-1:0]   shift_q,   shift_d;
    logic [BCD_W-1:0]   shadow_q,  shadow_d;
    logic               scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [BCD_W-1:0]   disp_q,    disp_d;
    logic               ovf_q,     ovf_d;
    logic               valid_q,   valid_d;
    logic               busy_q,    busy_d;

    logic [BCD_W-1:0]   adj;

    // Seven-segment pattern for one BCD digit, active-low, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Add-3 correction of every shadow digit that would exceed 9 after doubling.
    always_comb begin
        adj = shadow_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shadow_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = shadow_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath updates for the conversion FSM.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d   = value;
                    shadow_d  = '0;
                    scratch_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shadow_d  = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                scratch_d = scratch_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (scratch_q) begin
                    disp_d = {DIGITS{4'd9}};
                    ovf_d  = 1'b1;
                end else begin
                    disp_d = shadow_q;
                    ovf_d  = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            shadow_q  <= '0;
            scratch_q <= 1'b0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Segment decode from the committed display bank, never from the shadow.
    always_comb begin
        logic [3:0] dig;
        logic [6:0] seg;
`ifdef SCORE_SEG_LZ_BLANK_EN
        logic       lead;
        lead = 1'b1;
`endif
        hex = '0;
        dig = '0;
        seg = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            dig = disp_q[4*i +: 4];
            seg = seg7(dig);
`ifdef SCORE_SEG_LZ_BLANK_EN
            if (lead && (dig == 4'd0) && (i != 0)) begin
                seg = 7'h7F;
            end else begin
                lead = 1'b0;
            end
`endif
            hex[7*i +: 7] = seg;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_score_seg_display.sv
// Directed bench for score_seg_display (DIGITS=6, BIN_W=20) with hand-computed
// segment patterns; follows SCORE_SEG_LZ_BLANK_EN for leading-digit blanking.
module tb_score_seg_display;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned BIN_W  = 20;

`ifdef SCORE_SEG_LZ_BLANK_EN
    localparam logic [41:0] HEX_RST  = {{5{7'h7F}}, 7'h40};
    localparam logic [41:0] HEX_1234 = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [41:0] HEX_7    = {{5{7'h7F}}, 7'h78};
    localparam logic [41:0] HEX_42   = {{4{7'h7F}}, 7'h19, 7'h24};
    localparam logic [41:0] HEX_500  = {{3{7'h7F}}, 7'h12, 7'h40, 7'h40};
    localparam logic [41:0] HEX_3    = {{5{7'h7F}}, 7'h30};
`else
    localparam logic [41:0] HEX_RST  = {6{7'h40}};
    localparam logic [41:0] HEX_1234 = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [41:0] HEX_7    = {{5{7'h40}}, 7'h78};
    localparam logic [41:0] HEX_42   = {{4{7'h40}}, 7'h19, 7'h24};
    localparam logic [41:0] HEX_500  = {{3{7'h40}}, 7'h12, 7'h40, 7'h40};
    localparam logic [41:0] HEX_3    = {{5{7'h40}}, 7'h30};
`endif
    localparam logic [41:0] HEX_NINES = {6{7'h10}};

    logic               clock;
    logic               resetn;
    logic               load;
    logic [BIN_W-1:0]   value;
    logic               busy;
    logic               valid;
    logic               overflow;
    logic [7*DIGITS-1:0] hex;

    int n_checks;
    int n_pass;

    score_seg_display #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow),
        .hex      (hex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: pulses load with v, optionally re-asserts load with
    // inj_v at negedges inj_a/inj_b, and observes len following negedges.
    task automatic run(input logic [BIN_W-1:0] v, input int inj_a, input int inj_b,
                       input logic [BIN_W-1:0] inj_v, input int len,
                       output int busy_n, output int valid_n,
                       output int first_v, output int last_v);
        busy_n  = 0;
        valid_n = 0;
        first_v = -1;
        last_v  = -1;
        load    = 1'b1;
        value   = v;
        for (int n = 1; n <= len; n++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (valid) begin
                valid_n++;
                if (first_v < 0) first_v = n;
                last_v = n;
            end
            load  = (n == inj_a) || (n == inj_b);
            value = load ? inj_v : '0;
        end
        load  = 1'b0;
        value = '0;
    endtask

    initial begin
        int bn, vn, fv, lv;
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b0;
        load     = 1'b0;
        value    = '0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        // 1: reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_hex", 64'(hex), 64'(HEX_RST));

        // 2: 1234
        run(20'd1234, -1, -1, '0, 24, bn, vn, fv, lv);
        check("1234_busy_cycles", 64'(bn), 64'd21);
        check("1234_valid_count", 64'(vn), 64'd1);
        check("1234_valid_at", 64'(fv), 64'd22);
        check("1234_hex", 64'(hex), 64'(HEX_1234));
        check("1234_ovf", 64'(overflow), 64'd0);

        // 3: saturation boundary
        run(20'd999999, -1, -1, '0, 24, bn, vn, fv, lv);
        check("999999_hex", 64'(hex), 64'(HEX_NINES));
        check("999999_ovf", 64'(overflow), 64'd0);
        run(20'd1000000, -1, -1, '0, 24, bn, vn, fv, lv);
        check("1000000_hex", 64'(hex), 64'(HEX_NINES));
        check("1000000_ovf", 64'(overflow), 64'd1);
        check("1000000_valid_at", 64'(fv), 64'd22);
        run(20'd7, -1, -1, '0, 24, bn, vn, fv, lv);
        check("7_hex", 64'(hex), 64'(HEX_7));
        check("7_ovf", 64'(overflow), 64'd0);

        // 4: loads while busy (cycle 5 and the DONE cycle) are ignored
        run(20'd42, 5, 21, 20'd55, 26, bn, vn, fv, lv);
        check("42_busy_cycles", 64'(bn), 64'd21);
        check("42_valid_count", 64'(vn), 64'd1);
        check("42_hex", 64'(hex), 64'(HEX_42));

        // 5: reset mid-conversion
        load  = 1'b1;
        value = 20'd500;
        for (int n = 1; n < 10; n++) begin
            @(negedge clock);
            load  = 1'b0;
            value = '0;
        end
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        check("abort_hex", 64'(hex), 64'(HEX_RST));
        @(negedge clock);
        resetn = 1'b1;
        bn = 0;
        vn = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (busy) bn++;
            if (valid) vn++;
        end
        check("abort_no_busy", 64'(bn), 64'd0);
        check("abort_no_valid", 64'(vn), 64'd0);
        run(20'd500, -1, -1, '0, 24, bn, vn, fv, lv);
        check("500_valid_at", 64'(fv), 64'd22);
        check("500_hex", 64'(hex), 64'(HEX_500));

        // 6: back-to-back, second load in the cycle after the first valid
        run(20'd88, 23, -1, 20'd3, 48, bn, vn, fv, lv);
        check("b2b_valid_count", 64'(vn), 64'd2);
        check("b2b_first_valid", 64'(fv), 64'd22);
        check("b2b_second_valid", 64'(lv), 64'd45);
        check("b2b_busy_cycles", 64'(bn), 64'd42);
        check("b2b_hex", 64'(hex), 64'(HEX_3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
